// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: byte stream in, preamble/SFD/payload[/FCS] out, then a fixed inter-frame gap.
// Define GMII_TX_FCS_GEN_EN to append a CRC-32 FCS after the EOP byte.
module gmii_tx_mac #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txg_srdy,
  output logic       txg_drdy,
  input  logic [1:0] txg_code,
  input  logic [7:0] txg_data,
  output logic       gmii_tx_dv,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_er,
  output logic       tx_frame_done,
  output logic       tx_underrun,
  output logic [2:0] dbg_state
);

  localparam logic [1:0] CODE_SOP    = 2'd0;
  localparam logic [1:0] CODE_EOP    = 2'd2;
  localparam logic [1:0] CODE_BADEOP = 2'd3;

`ifdef GMII_TX_FCS_GEN_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SFD   = 3'd2,
    S_DATA  = 3'd3,
    S_IFG   = 3'd4,
    S_DRAIN = 3'd5,
    S_FCS   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SFD   = 3'd2,
    S_DATA  = 3'd3,
    S_IFG   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`endif

  state_t     state;
  logic [3:0] pre_cnt;
  logic [4:0] ifg_cnt;

  assign dbg_state = state;

`ifdef GMII_TX_FCS_GEN_EN
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  logic [31:0] crc;
  logic [1:0]  fcs_idx;
  logic [31:0] fcs_word;

  assign fcs_word = ~crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // Handshake: a byte moves when txg_srdy && txg_drdy on a rising clk edge; txg_code/txg_data
  // must be stable while txg_srdy is high. A SOP is only ever consumed in SFD, never in IDLE/DATA/DRAIN.
  always_comb begin
    txg_drdy = 1'b0;
    case (state)
      S_IDLE:          txg_drdy = txg_srdy && (txg_code != CODE_SOP);
      S_SFD:           txg_drdy = 1'b1;
      S_DATA, S_DRAIN: txg_drdy = !(txg_srdy && (txg_code == CODE_SOP));
      default:         txg_drdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pre_cnt       <= 4'd0;
      ifg_cnt       <= 5'd0;
      gmii_tx_dv    <= 1'b0;
      gmii_txd      <= 8'h00;
      gmii_tx_er    <= 1'b0;
      tx_frame_done <= 1'b0;
      tx_underrun   <= 1'b0;
`ifdef GMII_TX_FCS_GEN_EN
      crc           <= CRC_INIT;
      fcs_idx       <= 2'd0;
`endif
    end else begin
      gmii_tx_dv    <= 1'b0;
      gmii_txd      <= 8'h00;
      gmii_tx_er    <= 1'b0;
      tx_frame_done <= 1'b0;
      tx_underrun   <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef GMII_TX_FCS_GEN_EN
          crc <= CRC_INIT;
`endif
          // The first preamble byte leaves on the same edge that sees the waiting SOP.
          if (txg_srdy && (txg_code == CODE_SOP)) begin
            gmii_tx_dv <= 1'b1;
            gmii_txd   <= 8'h55;
            pre_cnt    <= 4'd1;
            state      <= S_PRE;
          end
        end
        S_PRE: begin
          gmii_tx_dv <= 1'b1;
          if (pre_cnt == 4'(PREAMBLE_LEN)) begin
            gmii_txd <= 8'hD5;
            state    <= S_SFD;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + 4'd1;
          end
        end
        S_SFD, S_DATA: begin
          gmii_tx_dv <= 1'b1;
          if (!txg_srdy) begin
            gmii_tx_er  <= 1'b1;
            tx_underrun <= 1'b1;
            state       <= S_DRAIN;
          end else if ((state == S_DATA) && (txg_code == CODE_SOP)) begin
            // Next frame arrived before this one ended: abort and leave the SOP waiting.
            gmii_tx_er  <= 1'b1;
            tx_underrun <= 1'b1;
            ifg_cnt     <= 5'd0;
            state       <= S_IFG;
          end else begin
            gmii_txd <= txg_data;
`ifdef GMII_TX_FCS_GEN_EN
            crc      <= crc_byte(crc, txg_data);
`endif
            case (txg_code)
              CODE_EOP: begin
`ifdef GMII_TX_FCS_GEN_EN
                fcs_idx <= 2'd0;
                state   <= S_FCS;
`else
                tx_frame_done <= 1'b1;
                ifg_cnt       <= 5'd0;
                state         <= S_IFG;
`endif
              end
              CODE_BADEOP: begin
                gmii_tx_er <= 1'b1;
                ifg_cnt    <= 5'd0;
                state      <= S_IFG;
              end
              default: state <= S_DATA;
            endcase
          end
        end
`ifdef GMII_TX_FCS_GEN_EN
        S_FCS: begin
          gmii_tx_dv <= 1'b1;
          gmii_txd   <= fcs_word[{fcs_idx, 3'b000} +: 8];
          if (fcs_idx == 2'd3) begin
            tx_frame_done <= 1'b1;
            ifg_cnt       <= 5'd0;
            state         <= S_IFG;
          end else begin
            fcs_idx <= fcs_idx + 2'd1;
          end
        end
`endif
        S_IFG: begin
          if (ifg_cnt == 5'(IFG_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 5'd1;
          end
        end
        S_DRAIN: begin
          if (txg_srdy && (txg_code != 2'd1)) begin
            ifg_cnt <= 5'd0;
            state   <= S_IFG;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
